// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// State encoding, default base address and half-word selects.
package mem_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Memory-stage data-memory controller: each 32-bit access is split
// into two half-word cycles on a 16-bit SRAM, stalling via ready.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam bit HOLD = (WAIT_CYCLES > 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [SRAM_AW-2:0] widx_q, widx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;

    logic        req;
    logic        last;
    logic        half;
    logic [31:0] offs;
    logic        unused_offs;

    assign req  = mem_r_en | mem_w_en;
    assign offs = address - BASE_ADDR;
    assign last = (cnt_q == CNT_LAST);
    assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;
        half        = HALF_LO;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    wr_d    = mem_w_en;
                    widx_d  = offs[SRAM_AW:2];
                    wdata_d = wr_data;
                end
            end
            ST_LOW: begin
                if (last) begin
                    if (!wr_q) rd_data_d[15:0] = sram_dq_in;
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HIGH: begin
                if (last) begin
                    if (!wr_q) rd_data_d[31:16] = sram_dq_in;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pad outputs are registered, so derive them from the next state.
        if (state_d == ST_LOW || state_d == ST_HIGH) begin
            half        = (state_d == ST_HIGH) ? HALF_HI : HALF_LO;
            sram_addr_d = {widx_d, half};
            oe_d        = wr_d;
            dq_out_d    = half ? wdata_d[31:16] : wdata_d[15:0];
            we_n_d      = ~(wr_d & (!HOLD || cnt_d != CNT_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            widx_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ((state_q == ST_IDLE) & ~req) | (state_q == ST_DONE);
    assign rd_data     = rd_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl with an inline 16-bit SRAM
// model and a half-word reference memory.
module tb_mem_sram_ctrl;

    localparam int          AW   = 18;
    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk;
    logic          rst;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [31:0]   address;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    mem_sram_ctrl #(
        .BASE_ADDR  (BASE),
        .SRAM_AW    (AW),
        .WAIT_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sram_model_16: a write commits once its strobe and hold cycle complete
    logic [15:0] sram [0:(1<<AW)-1];
    logic        strobe_seen;

    always_ff @(posedge clk) begin
        if (rst || !sram_dq_oe) begin
            strobe_seen <= 1'b0;
        end else if (!sram_we_n) begin
            strobe_seen <= 1'b1;
            if (W == 1) sram[sram_addr] <= sram_dq_out;
        end else if (strobe_seen) begin
            sram[sram_addr] <= sram_dq_out;
            strobe_seen     <= 1'b0;
        end
    end

    assign sram_dq_in = sram_dq_oe ? sram_dq_out : sram[sram_addr];

    int checks = 0;
    int errors = 0;

    logic [15:0]   ref_h [int];
    logic [31:0]   last_rd;
    int            lows;
    logic [15:0]   we_mask;
    logic [15:0]   oe_mask;
    logic [AW-1:0] samp_addr [0:15];
    logic [31:0]   done_rd;
    bit            timed_out;

    function automatic int haddr(input logic [31:0] a, input bit h);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return int'(((w % (32'd1 << (AW - 1))) << 1) | {31'd0, h});
    endfunction

    function automatic logic [15:0] exp_we(input bit w);
        logic [15:0] m;
        m = '0;
        for (int i = 1; i <= 2 * W; i++)
            if (w && (W == 1 || ((i - 1) % W) != W - 1)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] exp_oe(input bit w);
        logic [15:0] m;
        m = '0;
        for (int i = 1; i <= 2 * W; i++) m[i] = w;
        return m;
    endfunction

    task automatic idle_inputs();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address  = '0;
        wr_data  = '0;
    endtask

    // Drive one request from a negedge and record pad activity until ready.
    task automatic run_access(input bit w, input bit r,
                              input logic [31:0] a, input logic [31:0] d);
        mem_w_en  = w;
        mem_r_en  = r;
        address   = a;
        wr_data   = d;
        lows      = 0;
        we_mask   = '0;
        oe_mask   = '0;
        timed_out = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (ready) begin
                done_rd = rd_data;
                return;
            end
            if (!sram_we_n) we_mask[i] = 1'b1;
            if (sram_dq_oe) oe_mask[i] = 1'b1;
            samp_addr[i] = sram_addr;
            lows++;
            @(negedge clk);
        end
        timed_out = 1'b1;
        done_rd   = rd_data;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", ready);
        end
        checks++;
        if (rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
        checks++;
        if (sram_addr !== '0) begin
            errors++; $display("FAIL reset_sram_addr got %h want 0", sram_addr);
        end
        checks++;
        if (sram_dq_out !== 16'd0) begin
            errors++; $display("FAIL reset_dq_out got %h want 0", sram_dq_out);
        end
        checks++;
        if (sram_dq_oe !== 1'b0) begin
            errors++; $display("FAIL reset_oe got %b want 0", sram_dq_oe);
        end
        checks++;
        if (sram_we_n !== 1'b1) begin
            errors++; $display("FAIL reset_we_n got %b want 1", sram_we_n);
        end
        rst     = 1'b0;
        last_rd = '0;
        @(negedge clk);
    endtask

    task automatic test_store();
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        ref_h[haddr(32'd1024, 1'b0)] = 16'hBEEF;
        ref_h[haddr(32'd1024, 1'b1)] = 16'hDEAD;
        checks++;
        if (timed_out || lows != 1 + 2 * W) begin
            errors++; $display("FAIL store_stall got %0d want %0d", lows, 1 + 2 * W);
        end
        checks++;
        if (we_mask !== exp_we(1'b1)) begin
            errors++; $display("FAIL store_we_n got %b want %b", we_mask, exp_we(1'b1));
        end
        checks++;
        if (oe_mask !== exp_oe(1'b1)) begin
            errors++; $display("FAIL store_oe got %b want %b", oe_mask, exp_oe(1'b1));
        end
        for (int i = 1; i <= 2 * W; i++) begin
            checks++;
            if (int'(samp_addr[i]) != haddr(32'd1024, (i > W))) begin
                errors++;
                $display("FAIL store_addr[%0d] got %0d want %0d",
                         i, samp_addr[i], haddr(32'd1024, (i > W)));
            end
        end
        checks++;
        if (sram[0] !== 16'hBEEF || sram[1] !== 16'hDEAD) begin
            errors++; $display("FAIL store_sram got %h_%h want dead_beef", sram[1], sram[0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL store_idle_ready got %b want 1", ready);
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        run_access(1'b0, 1'b1, 32'd1024, 32'h0);
        checks++;
        if (timed_out || lows != 1 + 2 * W) begin
            errors++; $display("FAIL load_stall got %0d want %0d", lows, 1 + 2 * W);
        end
        checks++;
        if (oe_mask !== 16'd0 || we_mask !== 16'd0) begin
            errors++; $display("FAIL load_pad got oe %b we %b want 0", oe_mask, we_mask);
        end
        checks++;
        if (done_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_data got %h want deadbeef", done_rd);
        end
        last_rd = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_addr_map();
        run_access(1'b1, 1'b0, 32'd1036, 32'h12345678);
        ref_h[haddr(32'd1036, 1'b0)] = 16'h5678;
        ref_h[haddr(32'd1036, 1'b1)] = 16'h1234;
        checks++;
        if (sram[6] !== 16'h5678 || sram[7] !== 16'h1234) begin
            errors++; $display("FAIL map_sram got %h_%h want 1234_5678", sram[7], sram[6]);
        end
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd1036, 32'h0);
        checks++;
        if (done_rd !== 32'h12345678) begin
            errors++; $display("FAIL map_load got %h want 12345678", done_rd);
        end
        @(negedge clk);
        // Upper address bits are truncated onto the same SRAM word
        run_access(1'b0, 1'b1, 32'd1036 + 32'h80000, 32'h0);
        checks++;
        if (done_rd !== 32'h12345678) begin
            errors++; $display("FAIL map_wrap got %h want 12345678", done_rd);
        end
        last_rd = 32'h12345678;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int rdy_hi;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0);
        checks++;
        if (timed_out || lows != 1 + 2 * W || done_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL b2b_first got %0d/%h want %0d/deadbeef",
                               lows, done_rd, 1 + 2 * W);
        end
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd1036, 32'h0);
        checks++;
        if (timed_out || lows != 1 + 2 * W || done_rd !== 32'h12345678) begin
            errors++; $display("FAIL b2b_second got %0d/%h want %0d/12345678",
                               lows, done_rd, 1 + 2 * W);
        end
        last_rd = 32'h12345678;
        @(negedge clk);
        idle_inputs();
        rdy_hi = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ready === 1'b1 && sram_dq_oe === 1'b0) rdy_hi++;
            @(negedge clk);
        end
        checks++;
        if (rdy_hi != 4) begin
            errors++; $display("FAIL b2b_no_repeat got %0d want 4", rdy_hi);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] v;
        v = $urandom;
        run_access(1'b1, 1'b0, 32'd1040, v);
        ref_h[haddr(32'd1040, 1'b0)] = v[15:0];
        ref_h[haddr(32'd1040, 1'b1)] = v[31:16];
        @(negedge clk);
        mem_w_en = 1'b1;
        address  = 32'd1040;
        wr_data  = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pads got rdy %b we_n %b oe %b want 1 1 0",
                               ready, sram_we_n, sram_dq_oe);
        end
        checks++;
        if (rd_data !== 32'd0 || sram_addr !== '0) begin
            errors++; $display("FAIL rst_mid_regs got %h/%h want 0/0", rd_data, sram_addr);
        end
        rst     = 1'b0;
        last_rd = '0;
        ref_h[haddr(32'd1040, 1'b0)] = 16'hF00D;
        checks++;
        if (sram[8] !== 16'hF00D || sram[9] !== v[31:16]) begin
            errors++; $display("FAIL rst_mid_sram got %h_%h want %h_f00d",
                               sram[9], sram[8], v[31:16]);
        end
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd1040, 32'h0);
        checks++;
        if (done_rd !== {v[31:16], 16'hF00D}) begin
            errors++; $display("FAIL rst_mid_load got %h want %h", done_rd, {v[31:16], 16'hF00D});
        end
        last_rd = done_rd;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_idle_simul();
        int rdy_hi;
        logic [31:0] v;
        rdy_hi = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (ready === 1'b1) rdy_hi++;
            @(negedge clk);
        end
        checks++;
        if (rdy_hi != 6) begin
            errors++; $display("FAIL idle_ready got %0d want 6", rdy_hi);
        end
        v = $urandom;
        run_access(1'b1, 1'b1, 32'd1044, v);
        ref_h[haddr(32'd1044, 1'b0)] = v[15:0];
        ref_h[haddr(32'd1044, 1'b1)] = v[31:16];
        checks++;
        if (we_mask !== exp_we(1'b1) || oe_mask !== exp_oe(1'b1)) begin
            errors++; $display("FAIL simul_write got we %b oe %b want %b %b",
                               we_mask, oe_mask, exp_we(1'b1), exp_oe(1'b1));
        end
        checks++;
        if (done_rd !== last_rd) begin
            errors++; $display("FAIL simul_rd_kept got %h want %h", done_rd, last_rd);
        end
        checks++;
        if (sram[10] !== v[15:0] || sram[11] !== v[31:16]) begin
            errors++; $display("FAIL simul_sram got %h_%h want %h", sram[11], sram[10], v);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d, want;
            bit          w, r;
            int          sel, h0, h1;
            a   = BASE + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a + 32'h80000;
            d   = $urandom;
            sel = $urandom_range(0, 2);
            w   = (sel != 0);
            r   = (sel != 1);
            h0  = haddr(a, 1'b0);
            h1  = haddr(a, 1'b1);
            if (!w && !(ref_h.exists(h0) && ref_h.exists(h1))) begin
                w = 1'b1;
                r = 1'b0;
            end
            want = w ? last_rd : {ref_h[h1], ref_h[h0]};
            run_access(w, r, a, d);
            if (w) begin
                ref_h[h0] = d[15:0];
                ref_h[h1] = d[31:16];
            end else begin
                last_rd = want;
            end
            checks++;
            if (timed_out || lows != 1 + 2 * W) begin
                errors++; $display("FAIL rand%0d_stall got %0d want %0d", n, lows, 1 + 2 * W);
            end
            checks++;
            if (we_mask !== exp_we(w) || oe_mask !== exp_oe(w)) begin
                errors++; $display("FAIL rand%0d_pads got we %b oe %b want %b %b",
                                   n, we_mask, oe_mask, exp_we(w), exp_oe(w));
            end
            checks++;
            if (int'(samp_addr[1]) != h0 || int'(samp_addr[2 * W]) != h1) begin
                errors++; $display("FAIL rand%0d_addr got %0d/%0d want %0d/%0d",
                                   n, samp_addr[1], samp_addr[2 * W], h0, h1);
            end
            checks++;
            if (done_rd !== want) begin
                errors++; $display("FAIL rand%0d_rd got %h want %h", n, done_rd, want);
            end
            if (w) begin
                checks++;
                if (sram[h0] !== d[15:0] || sram[h1] !== d[31:16]) begin
                    errors++; $display("FAIL rand%0d_sram got %h_%h want %h",
                                       n, sram[h1], sram[h0], d);
                end
            end
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                idle_inputs();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_store();
        test_load();
        test_addr_map();
        test_back_to_back();
        test_reset_mid_write();
        test_idle_simul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
